// File: rtl/dist_ram_fifo.sv
// Single-clock FIFO on LUT RAM with async read and first-word fall-through.
// Ports: CLK/RST_N, WR_EN/WR_DATA, RD_EN/RD_DATA, FULL/AFULL/EMPTY/AEMPTY, OVERFLOW/UNDERFLOW, COUNT.
module dist_ram_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int AFULL_LVL  = DEPTH - 2,
  parameter int AEMPTY_LVL = 1
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     WR_EN,
  input  logic [WIDTH-1:0]         WR_DATA,
  output logic                     FULL,
  output logic                     AFULL,
  output logic                     OVERFLOW,
  input  logic                     RD_EN,
  output logic [WIDTH-1:0]         RD_DATA,
  output logic                     EMPTY,
  output logic                     AEMPTY,
  output logic                     UNDERFLOW,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int A = $clog2(DEPTH);

  localparam logic [A:0] L_DEPTH  = (A+1)'(DEPTH);
  localparam logic [A:0] L_AFULL  = (A+1)'(AFULL_LVL);
  localparam logic [A:0] L_AEMPTY = (A+1)'(AEMPTY_LVL);
  localparam logic [A:0] L_ZERO   = '0;

  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [A-1:0] r_wr_ptr;
  logic [A-1:0] r_rd_ptr;
  logic [A:0]   r_count;
  logic         r_full;
  logic         r_empty;
  logic         r_afull;
  logic         r_aempty;
  logic         r_ovf;
  logic         r_unf;

  logic         w_wr_acc;
  logic         w_rd_acc;
  logic [A:0]   w_count_nxt;
  logic         w_full_nxt;
  logic         w_empty_nxt;
  logic         w_afull_nxt;
  logic         w_aempty_nxt;

  // A write into a full FIFO is allowed when the head is popped on the
  // same edge; the freed slot is exactly the one wr_ptr points at.
  assign w_wr_acc = WR_EN & (~r_full | RD_EN);
  assign w_rd_acc = RD_EN & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + (A+1)'(1);
      2'b01:   w_count_nxt = r_count - (A+1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  assign w_full_nxt   = (w_count_nxt == L_DEPTH);
  assign w_empty_nxt  = (w_count_nxt == L_ZERO);
  assign w_afull_nxt  = (w_count_nxt >= L_AFULL);
  assign w_aempty_nxt = (w_count_nxt <= L_AEMPTY);

  // Storage has no reset so it maps onto LUT RAM. The RST_N gate keeps a
  // write coinciding with reset assertion from landing in memory.
  always_ff @(posedge CLK) begin
    if (w_wr_acc && RST_N) begin
      r_mem[r_wr_ptr] <= WR_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + A'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + A'(1);
      end
      r_count  <= w_count_nxt;
      r_full   <= w_full_nxt;
      r_empty  <= w_empty_nxt;
      r_afull  <= w_afull_nxt;
      r_aempty <= w_aempty_nxt;
      r_ovf    <= WR_EN & r_full & ~RD_EN;
      r_unf    <= RD_EN & r_empty;
    end
  end

  // Head word straight from the RAM read port: no output register.
  assign RD_DATA   = r_mem[r_rd_ptr];
  assign FULL      = r_full;
  assign EMPTY     = r_empty;
  assign AFULL     = r_afull;
  assign AEMPTY    = r_aempty;
  assign OVERFLOW  = r_ovf;
  assign UNDERFLOW = r_unf;
  assign COUNT     = r_count;

endmodule

// File: tb/tb_dist_ram_fifo.sv
// Scoreboard bench for dist_ram_fifo over four parameter sets.
// Each set keeps a reference queue; a negedge monitor compares all outputs.
module tb_dist_ram_fifo;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int ndone  = 0;

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int D   = (g == 0) ? 16 : (g == 1) ? 4 : (g == 2) ? 2 : 256;
    localparam int W   = (g == 0) ? 8 : (g == 1) ? 33 : (g == 2) ? 1 : 64;
    localparam int AFL = (g >= 2) ? D : D - 2;
    localparam int AEL = (g >= 2) ? 0 : 1;
    localparam int A   = $clog2(D);

    logic         rst_n;
    logic         we;
    logic         re;
    logic [W-1:0] wd;
    logic [W-1:0] rd;
    logic         full;
    logic         afull;
    logic         ovf;
    logic         empty;
    logic         aempty;
    logic         unf;
    logic [A:0]   cnt;

    logic [W-1:0] q[$];
    bit           e_ovf;
    bit           e_unf;
    bit           active;

    dist_ram_fifo #(
      .WIDTH(W), .DEPTH(D), .AFULL_LVL(AFL), .AEMPTY_LVL(AEL)
    ) dut (
      .CLK(CLK), .RST_N(rst_n),
      .WR_EN(we), .WR_DATA(wd),
      .FULL(full), .AFULL(afull), .OVERFLOW(ovf),
      .RD_EN(re), .RD_DATA(rd),
      .EMPTY(empty), .AEMPTY(aempty), .UNDERFLOW(unf),
      .COUNT(cnt)
    );

    task automatic chk(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cfg%0d %s: got %0h expected %0h at %0t",
                 g, nm, a, e, $time);
      end
    endtask

    // Drive one cycle, then update the reference at the edge.
    task automatic cyc(input bit w, input bit r, input logic [W-1:0] d);
      int  sz;
      bit  wacc;
      bit  racc;
      we = w;
      re = r;
      wd = d;
      @(posedge CLK);
      sz    = q.size();
      racc  = r && (sz > 0);
      wacc  = w && ((sz < D) || r);
      e_ovf = w && (sz == D) && !r;
      e_unf = r && (sz == 0);
      if (racc) void'(q.pop_front());
      if (wacc) q.push_back(d);
      #1;
    endtask

    function automatic logic [W-1:0] rnd();
      logic [63:0] v;
      v = {$urandom(), $urandom()};
      return v[W-1:0];
    endfunction

    // Asynchronous reset in the middle of a cycle, with traffic pending.
    task automatic mid_reset();
      #1 rst_n = 1'b0;
      #1;
      chk("rst_count", 64'(cnt), 64'd0);
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_full", 64'(full), 64'd0);
      chk("rst_aempty", 64'(aempty), 64'd1);
      chk("rst_afull", 64'(afull), 64'd0);
      chk("rst_ovf", 64'(ovf), 64'd0);
      chk("rst_unf", 64'(unf), 64'd0);
      q.delete();
      e_ovf = 1'b0;
      e_unf = 1'b0;
      we = 1'b1;
      re = 1'b0;
      wd = rnd();
      @(posedge CLK);
      @(posedge CLK);
      #3 rst_n = 1'b1;
      we = 1'b0;
    endtask

    always @(negedge CLK) begin
      if (active) begin
        chk("count", 64'(cnt), 64'(q.size()));
        chk("full", 64'(full), 64'(q.size() == D));
        chk("empty", 64'(empty), 64'(q.size() == 0));
        chk("afull", 64'(afull), 64'(q.size() >= AFL));
        chk("aempty", 64'(aempty), 64'(q.size() <= AEL));
        chk("overflow", 64'(ovf), 64'(e_ovf));
        chk("underflow", 64'(unf), 64'(e_unf));
        if (q.size() > 0) chk("rd_data", 64'(rd), 64'(q[0]));
      end
    end

    initial begin
      int n;
      rst_n  = 1'b0;
      we     = 1'b0;
      re     = 1'b0;
      wd     = '0;
      active = 1'b0;
      e_ovf  = 1'b0;
      e_unf  = 1'b0;
      repeat (2) @(posedge CLK);
      #3 rst_n = 1'b1;
      active = 1'b1;
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, rnd());
      mid_reset();
      cyc(1'b0, 1'b1, rnd());
      cyc(1'b0, 1'b0, rnd());
      cyc(1'b0, 1'b0, rnd());
      if (D == 16) begin
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, W'(i));
        cyc(1'b1, 1'b0, W'(8'hEE));
        cyc(1'b0, 1'b0, W'(8'h00));
        cyc(1'b1, 1'b1, W'(8'hA5));
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, W'(8'h00));
        cyc(1'b0, 1'b0, W'(8'h00));
        cyc(1'b1, 1'b1, W'(8'h3C));
        cyc(1'b0, 1'b0, W'(8'h00));
        cyc(1'b0, 1'b1, W'(8'h00));
        cyc(1'b0, 1'b0, W'(8'h00));
      end
      n = (3 * D + 60 < 400) ? 400 : 3 * D + 60;
      for (int i = 0; i < n; i++)
        cyc($urandom_range(99) < 85, $urandom_range(99) < 20, rnd());
      for (int i = 0; i < n; i++)
        cyc($urandom_range(1), $urandom_range(1), rnd());
      for (int i = 0; i < n; i++)
        cyc($urandom_range(99) < 15, $urandom_range(99) < 85, rnd());
      cyc(1'b0, 1'b0, rnd());
      active = 1'b0;
      ndone++;
    end
  end

  initial begin
    fork
      wait (ndone == 4);
      #1_000_000;
    join_any
    if (ndone != 4) begin
      checks++;
      errors++;
      $display("FAIL timeout: finished %0d of 4 configurations", ndone);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
